// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit with segmented carry and valid/ready flow control.
// Each stage resolves one SEG-bit carry segment; the last stage doubles as the output register.
module adder_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);
  localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
  localparam int NSEG     = WIDTH / SEG_SAFE;

  generate
    if (SEG < 1) begin : g_bad_seg
      $fatal(1, "adder_pipe: SEG must be at least 1");
    end else if ((WIDTH % SEG_SAFE) != 0) begin : g_bad_width
      $fatal(1, "adder_pipe: WIDTH must be a multiple of SEG");
    end
  endgenerate

  logic             advance_s;
  logic             c0_s;
  logic [WIDTH-1:0] beff_s;

  // Per-stage inputs: stage 0 sees the preprocessed operands, stage k sees stage k-1
  logic [NSEG-1:0]  vld_src_s;
  logic [NSEG-1:0]  c_src_s;
  logic [WIDTH-1:0] a_src_s   [NSEG];
  logic [WIDTH-1:0] b_src_s   [NSEG];
  logic [WIDTH-1:0] sum_src_s [NSEG];
  logic [WIDTH-1:0] nsum_s    [NSEG];
  logic [SEG_SAFE:0] seg_s    [NSEG];
  logic             ovf_next_s;

  logic [NSEG-1:0]  valid_r;
  logic [NSEG-1:0]  carry_r;
  logic [WIDTH-1:0] a_r   [NSEG];
  logic [WIDTH-1:0] b_r   [NSEG];
  logic [WIDTH-1:0] sum_r [NSEG];
  logic             ovf_r;

  // Operand preprocessing and the single global advance enable
  always_comb begin
    advance_s = !valid_r[NSEG-1] || out_ready;
    if (SUB) begin
      beff_s = ~B;
      c0_s   = 1'b1;
    end else begin
      beff_s = B;
      c0_s   = CIN;
    end
  end

  // Stage source selection, one SEG-bit segment add per stage, merge into the skewed sum
  always_comb begin
    vld_src_s    = {NSEG{1'b0}};
    c_src_s      = {NSEG{1'b0}};
    vld_src_s[0] = in_valid;
    c_src_s[0]   = c0_s;
    a_src_s[0]   = A;
    b_src_s[0]   = beff_s;
    sum_src_s[0] = {WIDTH{1'b0}};
    for (int k = 1; k < NSEG; k++) begin
      vld_src_s[k] = valid_r[k-1];
      c_src_s[k]   = carry_r[k-1];
      a_src_s[k]   = a_r[k-1];
      b_src_s[k]   = b_r[k-1];
      sum_src_s[k] = sum_r[k-1];
    end
    for (int k = 0; k < NSEG; k++) begin
      seg_s[k] = {1'b0, a_src_s[k][k*SEG_SAFE +: SEG_SAFE]}
               + {1'b0, b_src_s[k][k*SEG_SAFE +: SEG_SAFE]}
               + {{SEG_SAFE{1'b0}}, c_src_s[k]};
      nsum_s[k] = sum_src_s[k];
      nsum_s[k][k*SEG_SAFE +: SEG_SAFE] = seg_s[k][SEG_SAFE-1:0];
    end
    // Overflow uses the operand MSBs skewed down to the final stage
    ovf_next_s = (a_src_s[NSEG-1][WIDTH-1] == b_src_s[NSEG-1][WIDTH-1]) &&
                 (nsum_s[NSEG-1][WIDTH-1] != a_src_s[NSEG-1][WIDTH-1]);
  end

  // Stage registers; the whole pipe, bubbles included, moves only on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NSEG{1'b0}};
      carry_r <= {NSEG{1'b0}};
      ovf_r   <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
      end
    end else if (advance_s) begin
      valid_r <= vld_src_s;
      ovf_r   <= ovf_next_s;
      for (int k = 0; k < NSEG; k++) begin
        a_r[k]     <= a_src_s[k];
        b_r[k]     <= b_src_s[k];
        sum_r[k]   <= nsum_s[k];
        carry_r[k] <= seg_s[k][SEG_SAFE];
      end
    end
  end

  // Output ports are taken straight from the final stage registers
  always_comb begin
    in_ready  = advance_s;
    out_valid = valid_r[NSEG-1];
    S         = sum_r[NSEG-1];
    COUT      = carry_r[NSEG-1];
    OVF       = ovf_r;
  end

endmodule
